// File: rtl/dram_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : dram_cmd_scheduler_if
// Description : Request-queue and command-output bundle of the DRAM command
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface dram_cmd_scheduler_if;
    logic        req_valid;
    logic [1:0]  req_opcode;
    logic [32:0] req_address;
    logic        req_ready;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [14:0] cmd_row;
    logic [7:0]  cmd_col;
    logic        done_valid;
    logic        busy;
    logic [31:0] dram_time;

    modport master (
        output req_valid, req_opcode, req_address,
        input  req_ready, cmd_valid, cmd_code, cmd_bg, cmd_bank, cmd_row,
               cmd_col, done_valid, busy, dram_time
    );

    modport slave (
        input  req_valid, req_opcode, req_address,
        output req_ready, cmd_valid, cmd_code, cmd_bg, cmd_bank, cmd_row,
               cmd_col, done_valid, busy, dram_time
    );
endinterface
`default_nettype wire

// File: rtl/dram_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dram_cmd_scheduler
// Description : In-order open-page DRAM command sequencer (ACT/RD/WR/PRE)
//               enforcing DDR4 bank timing in DRAM-cycle units.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_cmd_scheduler #(
    parameter int CLK_RATIO = 2,
    parameter int T_RCD     = 24,
    parameter int T_RP      = 24,
    parameter int T_RAS     = 52,
    parameter int T_CL      = 24,
    parameter int T_CWL     = 20,
    parameter int T_BURST   = 4
) (
    input  wire                  clk,
    input  wire                  rst_n,
    dram_cmd_scheduler_if.slave  bus
);
    localparam int PS_W = (CLK_RATIO > 1) ? $clog2(CLK_RATIO) : 1;
    localparam logic [PS_W-1:0] PS_MAX   = PS_W'(CLK_RATIO - 1);
    localparam logic [31:0]     T_RCD_W  = 32'(T_RCD);
    localparam logic [31:0]     T_RP_W   = 32'(T_RP);
    localparam logic [31:0]     T_RAS_W  = 32'(T_RAS);
    localparam logic [15:0]     RD_LAT   = 16'(T_CL + T_BURST);
    localparam logic [15:0]     WR_LAT   = 16'(T_CWL + T_BURST);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_PRE   = 3'd2;
    localparam logic [2:0] ST_ACT   = 3'd3;
    localparam logic [2:0] ST_RDWR  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [2:0] CMD_ACT = 3'd0;
    localparam logic [2:0] CMD_RD  = 3'd1;
    localparam logic [2:0] CMD_WR  = 3'd2;
    localparam logic [2:0] CMD_PRE = 3'd3;
    localparam logic [1:0] OP_WR   = 2'd1;
    localparam logic [1:0] OP_NOP  = 2'd3;

    logic [2:0]      state_q, state_d;
    logic [PS_W-1:0] prescaler_q;
    logic [31:0]     dram_time_q;
    logic [15:0]     lat_q;
    logic [1:0]      req_op_q, req_bg_q, req_bank_q;
    logic [14:0]     req_row_q;
    logic [7:0]      req_col_q;
    logic            cmd_valid_q, done_valid_q;
    logic [2:0]      cmd_code_q;
    logic [1:0]      cmd_bg_q, cmd_bank_q;
    logic [14:0]     cmd_row_q;
    logic [7:0]      cmd_col_q;

    logic            bank_open_q     [16];
    logic            bank_pre_seen_q [16];
    logic [14:0]     bank_row_q      [16];
    logic [31:0]     bank_act_q      [16];
    logic [31:0]     bank_pre_q      [16];

    logic        w_tick, w_accept, issue_d, done_d;
    logic [2:0]  code_d;
    logic [3:0]  w_idx;
    logic [31:0] w_since_act, w_since_pre;
    logic        w_unused_addr;

    assign w_tick        = (prescaler_q == PS_MAX);
    // A done pulse in flight blocks acceptance so the next request waits for a fresh tick.
    assign w_accept      = rst_n && w_tick && (state_q == ST_IDLE) &&
                           bus.req_valid && !done_valid_q;
    assign w_idx         = {req_bg_q, req_bank_q};
    assign w_since_act   = dram_time_q - bank_act_q[w_idx];
    assign w_since_pre   = dram_time_q - bank_pre_q[w_idx];
    assign w_unused_addr = ^bus.req_address[5:0];

    always_comb begin
        state_d = state_q;
        issue_d = 1'b0;
        code_d  = CMD_ACT;
        done_d  = 1'b0;
        if (w_tick) begin
            case (state_q)
                ST_IDLE:  if (w_accept && bus.req_opcode != OP_NOP) state_d = ST_CHECK;
                ST_CHECK: begin
                    if (!bank_open_q[w_idx])                state_d = ST_ACT;
                    else if (bank_row_q[w_idx] == req_row_q) state_d = ST_RDWR;
                    else                                     state_d = ST_PRE;
                end
                ST_PRE: if (w_since_act >= T_RAS_W) begin
                    issue_d = 1'b1;
                    code_d  = CMD_PRE;
                    state_d = ST_ACT;
                end
                ST_ACT: if (!bank_pre_seen_q[w_idx] || w_since_pre >= T_RP_W) begin
                    issue_d = 1'b1;
                    code_d  = CMD_ACT;
                    state_d = ST_RDWR;
                end
                ST_RDWR: if (w_since_act >= T_RCD_W) begin
                    issue_d = 1'b1;
                    code_d  = (req_op_q == OP_WR) ? CMD_WR : CMD_RD;
                    state_d = ST_DONE;
                end
                ST_DONE: if (lat_q <= 16'd1) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            prescaler_q  <= '0;
            dram_time_q  <= '0;
            lat_q        <= '0;
            req_op_q     <= '0;
            req_bg_q     <= '0;
            req_bank_q   <= '0;
            req_row_q    <= '0;
            req_col_q    <= '0;
            cmd_valid_q  <= 1'b0;
            done_valid_q <= 1'b0;
            cmd_code_q   <= '0;
            cmd_bg_q     <= '0;
            cmd_bank_q   <= '0;
            cmd_row_q    <= '0;
            cmd_col_q    <= '0;
            for (int i = 0; i < 16; i++) begin
                bank_open_q[i]     <= 1'b0;
                bank_pre_seen_q[i] <= 1'b0;
                bank_row_q[i]      <= '0;
                bank_act_q[i]      <= '0;
                bank_pre_q[i]      <= '0;
            end
        end else begin
            prescaler_q  <= w_tick ? '0 : prescaler_q + PS_W'(1);
            if (w_tick) dram_time_q <= dram_time_q + 32'd1;
            state_q      <= state_d;
            cmd_valid_q  <= issue_d;
            done_valid_q <= done_d;

            if (w_accept && bus.req_opcode != OP_NOP) begin
                req_op_q   <= bus.req_opcode;
                req_bg_q   <= bus.req_address[7:6];
                req_bank_q <= bus.req_address[9:8];
                req_row_q  <= bus.req_address[32:18];
                req_col_q  <= bus.req_address[17:10];
            end

            if (issue_d) begin
                cmd_code_q <= code_d;
                cmd_bg_q   <= req_bg_q;
                cmd_bank_q <= req_bank_q;
                cmd_row_q  <= req_row_q;
                cmd_col_q  <= req_col_q;
                case (code_d)
                    CMD_PRE: begin
                        bank_open_q[w_idx]     <= 1'b0;
                        bank_pre_seen_q[w_idx] <= 1'b1;
                        bank_pre_q[w_idx]      <= dram_time_q;
                    end
                    CMD_ACT: begin
                        bank_open_q[w_idx] <= 1'b1;
                        bank_row_q[w_idx]  <= req_row_q;
                        bank_act_q[w_idx]  <= dram_time_q;
                    end
                    CMD_WR:  lat_q <= WR_LAT;
                    default: lat_q <= RD_LAT;
                endcase
            end else if (w_tick && state_q == ST_DONE && lat_q != 16'd0) begin
                lat_q <= lat_q - 16'd1;
            end
        end
    end

    assign bus.req_ready  = w_accept;
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_code   = cmd_code_q;
    assign bus.cmd_bg     = cmd_bg_q;
    assign bus.cmd_bank   = cmd_bank_q;
    assign bus.cmd_row    = cmd_row_q;
    assign bus.cmd_col    = cmd_col_q;
    assign bus.done_valid = done_valid_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.dram_time  = dram_time_q;
endmodule
`default_nettype wire

// File: tb/tb_dram_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_cmd_scheduler
// Description : Scoreboard bench for dram_cmd_scheduler with a DRAM-cycle
//               timing model of the bank table.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dram_cmd_scheduler;
    localparam int CLK_RATIO = 2;
    localparam int T_RCD = 24, T_RP = 24, T_RAS = 52;
    localparam int T_CL = 24, T_CWL = 20, T_BURST = 4;
    localparam int K_DONE = 4;

    typedef struct {
        int          kind;
        logic [1:0]  bg;
        logic [1:0]  bank;
        logic [14:0] row;
        logic [7:0]  col;
        logic [31:0] t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dram_cmd_scheduler_if bus();

    dram_cmd_scheduler #(
        .CLK_RATIO(CLK_RATIO), .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS),
        .T_CL(T_CL), .T_CWL(T_CWL), .T_BURST(T_BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        m_open     [16];
    logic        m_pre_seen [16];
    logic [14:0] m_row      [16];
    logic [31:0] m_act      [16];
    logic [31:0] m_pre      [16];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] tmax(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_open[i] = 1'b0; m_pre_seen[i] = 1'b0;
            m_row[i] = '0; m_act[i] = '0; m_pre[i] = '0;
        end
    endtask

    // Commands and completions come out registered, one clk after their tick.
    always @(negedge clk) begin
        if (rst_n && bus.cmd_valid) begin
            if (q.size() == 0) chk("unexpected_cmd", bus.cmd_code, 7);
            else begin
                mon_e = q.pop_front();
                chk("cmd_code", bus.cmd_code, mon_e.kind);
                chk("cmd_bg",   bus.cmd_bg,   mon_e.bg);
                chk("cmd_bank", bus.cmd_bank, mon_e.bank);
                chk("cmd_row",  bus.cmd_row,  mon_e.row);
                chk("cmd_col",  bus.cmd_col,  mon_e.col);
                chk("cmd_time", bus.dram_time - 32'd1, mon_e.t);
            end
        end
        if (rst_n && bus.done_valid) begin
            if (q.size() == 0) chk("unexpected_done", bus.done_valid, 0);
            else begin
                mon_e = q.pop_front();
                chk("done_kind", K_DONE, mon_e.kind);
                chk("done_time", bus.dram_time - 32'd1, mon_e.t);
            end
        end
    end

    task automatic push(input int kind, input logic [32:0] a, input logic [31:0] t);
        exp_t e;
        e.kind = kind; e.bg = a[7:6]; e.bank = a[9:8];
        e.row = a[32:18]; e.col = a[17:10]; e.t = t;
        q.push_back(e);
    endtask

    // Called just after a negedge; returns just after a negedge.
    task automatic submit(input logic [1:0] op, input logic [32:0] a, output bit got);
        logic [31:0] x, t, tr;
        int idx;
        got = 1'b0;
        x   = '0;
        bus.req_valid = 1'b1; bus.req_opcode = op; bus.req_address = a;
        for (int i = 0; i < 4000 && !got; i++) begin
            #1;
            if (bus.req_ready) begin got = 1'b1; x = bus.dram_time; end
            else @(negedge clk);
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        if (got && op != 2'd3) begin
            idx = {a[7:6], a[9:8]};
            t = x + 32'd2;
            if (!(m_open[idx] && m_row[idx] == a[32:18])) begin
                if (m_open[idx]) begin
                    t = tmax(t, m_act[idx] + T_RAS);
                    push(3, a, t);
                    m_pre[idx] = t; m_pre_seen[idx] = 1'b1; m_open[idx] = 1'b0;
                    t = t + 32'd1;
                end
                if (m_pre_seen[idx]) t = tmax(t, m_pre[idx] + T_RP);
                push(0, a, t);
                m_act[idx] = t; m_open[idx] = 1'b1; m_row[idx] = a[32:18];
                t = t + 32'd1;
            end
            tr = tmax(t, m_act[idx] + T_RCD);
            push((op == 2'd1) ? 2 : 1, a, tr);
            push(K_DONE, a, tr + ((op == 2'd1) ? (T_CWL + T_BURST) : (T_CL + T_BURST)));
        end
        @(negedge clk);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.busy) ok = 1'b1;
        end
        if (!ok) chk("drain_timeout", q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_cmd_valid",  bus.cmd_valid,  0);
        chk("rst_done_valid", bus.done_valid, 0);
        chk("rst_busy",       bus.busy,       0);
        chk("rst_req_ready",  bus.req_ready,  0);
        chk("rst_dram_time",  bus.dram_time,  0);
        chk("rst_cmd_row",    bus.cmd_row,    0);
        q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        bit seen;
        bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_address = '0;
        @(negedge clk);
        do_reset();
        repeat (10) @(posedge clk);
        #1 chk("dram_time_rate", bus.dram_time, 5);
        @(negedge clk);

        // Closed-bank read, then a row hit with a different column.
        submit(2'd0, 33'h0_0000_0000, got);
        chk("busy_inflight", bus.busy, 1);
        drain();
        submit(2'd0, 33'h0_0000_0400, got);
        drain();

        // Row conflict right after ACT: PRE must wait for tRAS.
        do_reset();
        submit(2'd1, 33'h0_0000_0000, got);
        submit(2'd1, 33'h0_0004_0000, got);
        drain();

        // Different bank group/bank, then a hit back in bank 0 row 1.
        submit(2'd2, 33'h0_0000_02C0, got);
        drain();
        submit(2'd0, 33'h0_0004_0000, got);
        drain();

        // NOP: popped but produces nothing.
        submit(2'd3, 33'h0_0000_0000, got);
        chk("nop_ready", got, 1);
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (bus.busy) seen = 1'b1; end
        chk("nop_busy", seen, 0);

        // Reset during DONE abandons the request and clears the bank table.
        submit(2'd0, 33'h0_0000_0400, got);
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (q.size() == 1) seen = 1'b1;
        end
        chk("reach_done_state", seen, 1);
        repeat (4) @(negedge clk);
        do_reset();
        repeat (100) @(negedge clk);
        submit(2'd0, 33'h0_0000_0400, got);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
